// File: rtl/nx_rwreg_indirect_access_mt.sv
// Indirect read/write access to N_TABLES flop tables. Commands and data arrive over CSRs.
// Each table also has a dedicated 1-cycle hardware read port and write port.
module nx_rwreg_indirect_access_mt #(
  parameter int N_REG_ADDR_BITS = 11,
  parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = 11'h40C,
  parameter logic [N_REG_ADDR_BITS-1:0] DATA_ADDRESS = 11'h410,
  parameter int N_DATA_BITS = 64,
  parameter int N_ENTRIES   = 32,
  parameter int N_TABLES    = 2,
  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
  localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REG_ADDR_BITS-1:0]      addr,
  input  logic                            wr_stb,
  input  logic [N_DATA_BITS-1:0]          wr_dat,
  input  logic [3:0]                      cmnd_op,
  input  logic [AW-1:0]                   cmnd_addr,
  input  logic [TW-1:0]                   cmnd_table_id,
  output logic [2:0]                      stat_code,
  output logic [AW-1:0]                   stat_addr,
  output logic [TW-1:0]                   stat_table_id,
  output logic [4:0]                      stat_datawords,
  output logic [15:0]                     capability_lst,
  output logic [3:0]                      capability_type,
  output logic [N_DATA_BITS-1:0]          rd_dat,
  input  logic [N_TABLES*AW-1:0]          hw_rd_addr,
  output logic [N_TABLES*N_DATA_BITS-1:0] hw_rd_dat,
  input  logic [N_TABLES-1:0]             hw_wr_en,
  input  logic [N_TABLES*AW-1:0]          hw_wr_addr,
  input  logic [N_TABLES*N_DATA_BITS-1:0] hw_wr_dat,
  output logic [1:0]                      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_INIT = 2'd2
  } state_e;

  localparam logic [2:0] SC_READY    = 3'd0;
  localparam logic [2:0] SC_BUSY     = 3'd1;
  localparam logic [2:0] SC_ADDR_ERR = 3'd2;
  localparam logic [2:0] SC_OP_ERR   = 3'd3;
  localparam logic [2:0] SC_TBL_ERR  = 3'd4;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_INIT  = 4'd3;

  localparam logic [AW-1:0] LAST_ENTRY = AW'(N_ENTRIES - 1);
  localparam logic [AW:0]   ENTRIES_W  = (AW+1)'(N_ENTRIES);
  localparam logic [TW:0]   TABLES_W   = (TW+1)'(N_TABLES);

  state_e                  state_q;
  logic [2:0]              code_q;
  logic [AW-1:0]           stat_addr_q;
  logic [TW-1:0]           tid_q;
  logic [AW-1:0]           cnt_q;
  logic                    is_write_q;
  logic [N_DATA_BITS-1:0]  rd_dat_q;
  logic [N_DATA_BITS-1:0]  mem_q [N_TABLES][N_ENTRIES];
  logic [N_DATA_BITS-1:0]  hw_rd_q [N_TABLES];

  logic                    cmd_stb;
  logic                    data_stb;
  logic                    op_bad;
  logic                    tbl_bad;
  logic                    addr_bad;
  logic                    hw_stall;
  logic                    sw_we;
  logic [AW-1:0]           sw_waddr;
  logic [N_DATA_BITS-1:0]  sw_wdat;

  assign cmd_stb  = wr_stb && (addr == CMND_ADDRESS) && (state_q == ST_IDLE);
  assign data_stb = wr_stb && (addr == DATA_ADDRESS) && (state_q == ST_IDLE);
  assign op_bad   = cmnd_op > OP_INIT;
  assign tbl_bad  = {1'b0, cmnd_table_id} >= TABLES_W;
  assign addr_bad = {1'b0, cmnd_addr} >= ENTRIES_W;

  // A hardware write to the selected table always wins; the SW write or clear waits.
  assign hw_stall = hw_wr_en[tid_q];
  assign sw_we    = (((state_q == ST_EXEC) && is_write_q) || (state_q == ST_INIT)) && !hw_stall;
  assign sw_waddr = (state_q == ST_INIT) ? cnt_q : stat_addr_q;
  assign sw_wdat  = (state_q == ST_INIT) ? '0 : rd_dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      code_q      <= SC_READY;
      stat_addr_q <= '0;
      tid_q       <= '0;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      rd_dat_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_stb) begin
            stat_addr_q <= cmnd_addr;
            tid_q       <= cmnd_table_id;
            is_write_q  <= (cmnd_op == OP_WRITE);
            cnt_q       <= '0;
            if (op_bad)                             code_q <= SC_OP_ERR;
            else if (tbl_bad)                       code_q <= SC_TBL_ERR;
            else if (addr_bad && cmnd_op != OP_INIT) code_q <= SC_ADDR_ERR;
            else if (cmnd_op == OP_NOP)             code_q <= SC_READY;
            else begin
              code_q  <= SC_BUSY;
              state_q <= (cmnd_op == OP_INIT) ? ST_INIT : ST_EXEC;
            end
          end else if (data_stb) begin
            rd_dat_q <= wr_dat;
          end
        end
        ST_EXEC: begin
          if (!is_write_q) begin
            rd_dat_q <= mem_q[tid_q][stat_addr_q];
            state_q  <= ST_IDLE;
            code_q   <= SC_READY;
          end else if (!hw_stall) begin
            state_q <= ST_IDLE;
            code_q  <= SC_READY;
          end
        end
        ST_INIT: begin
          if (!hw_stall) begin
            if (cnt_q == LAST_ENTRY) begin
              state_q <= ST_IDLE;
              code_q  <= SC_READY;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          code_q  <= SC_READY;
        end
      endcase
    end
  end

  // Out-of-range hardware write addresses match no entry and are dropped.
  for (genvar t = 0; t < N_TABLES; t++) begin : g_tbl
    for (genvar e = 0; e < N_ENTRIES; e++) begin : g_ent
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_q[t][e] <= '0;
        end else if (hw_wr_en[t] && hw_wr_addr[t*AW +: AW] == AW'(e)) begin
          mem_q[t][e] <= hw_wr_dat[t*N_DATA_BITS +: N_DATA_BITS];
        end else if (sw_we && tid_q == TW'(t) && sw_waddr == AW'(e)) begin
          mem_q[t][e] <= sw_wdat;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hw_rd_q[t] <= '0;
      end else if ({1'b0, hw_rd_addr[t*AW +: AW]} < ENTRIES_W) begin
        hw_rd_q[t] <= mem_q[t][hw_rd_addr[t*AW +: AW]];
      end else begin
        hw_rd_q[t] <= '0;
      end
    end

    assign hw_rd_dat[t*N_DATA_BITS +: N_DATA_BITS] = hw_rd_q[t];
  end

  assign stat_code       = code_q;
  assign stat_addr       = stat_addr_q;
  assign stat_table_id   = tid_q;
  assign rd_dat          = rd_dat_q;
  assign stat_datawords  = 5'((N_DATA_BITS + 31) / 32);
  assign capability_lst  = 16'h800F;
  assign capability_type = 4'd1;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_nx_rwreg_indirect_access_mt.sv
// Bench for nx_rwreg_indirect_access_mt: a default instance plus a 40-entry, 3-table
// instance that exercises the range and error checks.
module tb_nx_rwreg_indirect_access_mt;
  localparam int AW = 5;
  localparam int TW = 1;
  localparam int DW = 64;
  localparam int NE = 32;
  localparam int NT = 2;
  localparam int EAW = 6;
  localparam int ETW = 2;
  localparam int ENT = 3;
  localparam logic [10:0] CMND = 11'h40C;
  localparam logic [10:0] DATA = 11'h410;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [10:0]       addr;
  logic              wr_stb;
  logic              e_wr_stb;
  logic [DW-1:0]     wr_dat;
  logic [3:0]        cmnd_op;
  logic [AW-1:0]     cmnd_addr;
  logic [TW-1:0]     cmnd_table_id;
  logic [2:0]        stat_code;
  logic [AW-1:0]     stat_addr;
  logic [TW-1:0]     stat_table_id;
  logic [4:0]        stat_datawords;
  logic [15:0]       capability_lst;
  logic [3:0]        capability_type;
  logic [DW-1:0]     rd_dat;
  logic [NT*AW-1:0]  hw_rd_addr;
  logic [NT*DW-1:0]  hw_rd_dat;
  logic [NT-1:0]     hw_wr_en;
  logic [NT*AW-1:0]  hw_wr_addr;
  logic [NT*DW-1:0]  hw_wr_dat;
  logic [1:0]        dbg_state;

  logic [EAW-1:0]    e_cmnd_addr;
  logic [ETW-1:0]    e_cmnd_tid;
  logic [2:0]        e_stat_code;
  logic [EAW-1:0]    e_stat_addr;
  logic [ETW-1:0]    e_stat_tid;
  logic [4:0]        e_stat_datawords;
  logic [15:0]       e_capability_lst;
  logic [3:0]        e_capability_type;
  logic [DW-1:0]     e_rd_dat;
  logic [ENT*EAW-1:0] e_hw_rd_addr;
  logic [ENT*DW-1:0]  e_hw_rd_dat;
  logic [ENT-1:0]     e_hw_wr_en;
  logic [ENT*EAW-1:0] e_hw_wr_addr;
  logic [ENT*DW-1:0]  e_hw_wr_dat;
  logic [1:0]         e_dbg_state;

  nx_rwreg_indirect_access_mt u_dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_stb(wr_stb), .wr_dat(wr_dat),
    .cmnd_op(cmnd_op), .cmnd_addr(cmnd_addr), .cmnd_table_id(cmnd_table_id),
    .stat_code(stat_code), .stat_addr(stat_addr), .stat_table_id(stat_table_id),
    .stat_datawords(stat_datawords), .capability_lst(capability_lst),
    .capability_type(capability_type), .rd_dat(rd_dat),
    .hw_rd_addr(hw_rd_addr), .hw_rd_dat(hw_rd_dat), .hw_wr_en(hw_wr_en),
    .hw_wr_addr(hw_wr_addr), .hw_wr_dat(hw_wr_dat), .dbg_state(dbg_state)
  );

  nx_rwreg_indirect_access_mt #(.N_ENTRIES(40), .N_TABLES(3)) u_err (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_stb(e_wr_stb), .wr_dat(wr_dat),
    .cmnd_op(cmnd_op), .cmnd_addr(e_cmnd_addr), .cmnd_table_id(e_cmnd_tid),
    .stat_code(e_stat_code), .stat_addr(e_stat_addr), .stat_table_id(e_stat_tid),
    .stat_datawords(e_stat_datawords), .capability_lst(e_capability_lst),
    .capability_type(e_capability_type), .rd_dat(e_rd_dat),
    .hw_rd_addr(e_hw_rd_addr), .hw_rd_dat(e_hw_rd_dat), .hw_wr_en(e_hw_wr_en),
    .hw_wr_addr(e_hw_wr_addr), .hw_wr_dat(e_hw_wr_dat), .dbg_state(e_dbg_state)
  );

  // reference model of the default instance
  logic [DW-1:0] mem_m [NT][NE];
  logic [DW-1:0] rd_m;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic csr_data(input logic [DW-1:0] d);
    addr = DATA; wr_dat = d; wr_stb = 1'b1;
    @(negedge clk);
    wr_stb = 1'b0;
  endtask

  task automatic send_cmd(input logic [3:0] op, input int t, input int a);
    cmnd_op = op; cmnd_table_id = TW'(t); cmnd_addr = AW'(a);
    addr = CMND; wr_stb = 1'b1;
    @(negedge clk);
    wr_stb = 1'b0;
  endtask

  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (stat_code == 3'd1 && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic hw_rd(input int t, input int a, output logic [DW-1:0] d);
    hw_rd_addr[t*AW +: AW] = AW'(a);
    @(negedge clk);
    d = hw_rd_dat[t*DW +: DW];
  endtask

  task automatic hw_wr(input int t, input int a, input logic [DW-1:0] d);
    hw_wr_en[t] = 1'b1; hw_wr_addr[t*AW +: AW] = AW'(a); hw_wr_dat[t*DW +: DW] = d;
    @(negedge clk);
    hw_wr_en[t] = 1'b0;
    mem_m[t][a] = d;
  endtask

  task automatic sw_write(input int t, input int a, input logic [DW-1:0] d);
    int n;
    csr_data(d); rd_m = d;
    send_cmd(4'd2, t, a);
    wait_ready(10, n);
    chk("sw_write_busy", 64'(n), 64'd1);
    mem_m[t][a] = rd_m;
  endtask

  task automatic sw_read(input int t, input int a);
    int n;
    send_cmd(4'd1, t, a);
    wait_ready(10, n);
    chk("sw_read_busy", 64'(n), 64'd1);
    rd_m = mem_m[t][a];
    chk("sw_read_data", rd_dat, rd_m);
    chk("sw_read_code", 64'(stat_code), 64'd0);
  endtask

  task automatic compare_all();
    for (int a = 0; a < NE; a++) begin
      for (int t = 0; t < NT; t++) hw_rd_addr[t*AW +: AW] = AW'(a);
      @(negedge clk);
      for (int t = 0; t < NT; t++) chk($sformatf("table_t%0d_a%0d", t, a), hw_rd_dat[t*DW +: DW], mem_m[t][a]);
    end
  endtask

  task automatic e_cmd(input logic [3:0] op, input int t, input int a);
    cmnd_op = op; e_cmnd_tid = ETW'(t); e_cmnd_addr = EAW'(a);
    addr = CMND; e_wr_stb = 1'b1;
    @(negedge clk);
    e_wr_stb = 1'b0;
  endtask

  task automatic e_hw_rd(input int t, input int a, output logic [DW-1:0] d);
    e_hw_rd_addr[t*EAW +: EAW] = EAW'(a);
    @(negedge clk);
    d = e_hw_rd_dat[t*DW +: DW];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, busy, t, a, t2, a2;
    logic [DW-1:0] d, x, ed;

    addr = '0; wr_stb = 1'b0; e_wr_stb = 1'b0; wr_dat = '0; cmnd_op = '0;
    cmnd_addr = '0; cmnd_table_id = '0; e_cmnd_addr = '0; e_cmnd_tid = '0;
    hw_rd_addr = '0; hw_wr_en = '0; hw_wr_addr = '0; hw_wr_dat = '0;
    e_hw_rd_addr = '0; e_hw_wr_en = '0; e_hw_wr_addr = '0; e_hw_wr_dat = '0;
    rd_m = '0;
    for (int i = 0; i < NT; i++) for (int j = 0; j < NE; j++) mem_m[i][j] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_stat_code", 64'(stat_code), 64'd0);
    chk("rst_stat_addr", 64'(stat_addr), 64'd0);
    chk("rst_stat_tid", 64'(stat_table_id), 64'd0);
    chk("rst_rd_dat", rd_dat, 64'd0);
    chk("rst_hw_rd0", hw_rd_dat[0 +: DW], 64'd0);
    chk("rst_hw_rd1", hw_rd_dat[DW +: DW], 64'd0);
    chk("rst_cap_lst", 64'(capability_lst), 64'h800F);
    chk("rst_datawords", 64'(stat_datawords), 64'd2);
    chk("rst_cap_type", 64'(capability_type), 64'd1);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_e_code", 64'(e_stat_code), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed write then read of table 1 entry 5
    d = 64'hDEAD_BEEF_0123_4567;
    csr_data(d); rd_m = d;
    chk("data_load", rd_dat, rd_m);
    send_cmd(4'd2, 1, 5);
    chk("write_code_busy", 64'(stat_code), 64'd1);
    wait_ready(10, n);
    chk("write_busy_cycles", 64'(n), 64'd1);
    mem_m[1][5] = rd_m;
    csr_data('0); rd_m = '0;
    chk("data_clear", rd_dat, 64'd0);
    sw_read(1, 5);
    chk("read_value", rd_dat, 64'hDEAD_BEEF_0123_4567);
    chk("read_stat_addr", 64'(stat_addr), 64'd5);
    chk("read_stat_tid", 64'(stat_table_id), 64'd1);
    hw_rd(1, 5, x);
    chk("hw_rd_t1a5", x, 64'hDEAD_BEEF_0123_4567);
    hw_rd(0, 5, x);
    chk("hw_rd_t0a5", x, 64'd0);

    // random writes and reads
    for (int i = 0; i < 10; i++) begin
      t = int'($urandom_range(0, 1)); a = int'($urandom_range(0, NE-1));
      d = {$urandom, $urandom};
      sw_write(t, a, d);
      t2 = int'($urandom_range(0, 1)); a2 = int'($urandom_range(0, NE-1));
      sw_read(t2, a2);
      hw_rd(t, a, x);
      chk("rnd_hw_rd", x, mem_m[t][a]);
    end

    // SW write colliding with three cycles of hardware writes
    d = {$urandom, $urandom} | 64'h2;
    csr_data(d); rd_m = d;
    send_cmd(4'd2, 0, 3);
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      if (stat_code == 3'd1) busy++;
      hw_wr_en[0] = 1'b1; hw_wr_addr[0 +: AW] = 5'd3; hw_wr_dat[0 +: DW] = 64'h1;
      @(negedge clk);
    end
    hw_wr_en[0] = 1'b0;
    mem_m[0][3] = 64'h1;
    wait_ready(10, n);
    busy += n;
    chk("conflict_busy", 64'(busy), 64'd4);
    mem_m[0][3] = rd_m;
    hw_rd(0, 3, x);
    chk("conflict_final", x, d);

    // fill table 0 by hardware, then INIT it with stray strobes mid-flight
    for (int i = 0; i < NE; i++) hw_wr(0, i, {$urandom, $urandom});
    d = {$urandom, $urandom};
    csr_data(d); rd_m = d;
    send_cmd(4'd3, 0, int'($urandom_range(0, NE-1)));
    busy = 0;
    while (stat_code == 3'd1 && busy < 100) begin
      busy++;
      if (busy == 5) begin
        cmnd_op = 4'd2; cmnd_table_id = 1'b1; cmnd_addr = 5'd7; addr = CMND; wr_stb = 1'b1;
      end else if (busy == 8) begin
        addr = DATA; wr_dat = ~d; wr_stb = 1'b1;
      end else begin
        wr_stb = 1'b0;
      end
      @(negedge clk);
    end
    wr_stb = 1'b0;
    chk("init_busy", 64'(busy), 64'd32);
    chk("init_code", 64'(stat_code), 64'd0);
    chk("init_rd_dat_kept", rd_dat, rd_m);
    chk("init_tid_kept", 64'(stat_table_id), 64'd0);
    for (int i = 0; i < NE; i++) mem_m[0][i] = '0;
    compare_all();

    // INIT of table 1 stalled by two hardware write cycles
    send_cmd(4'd3, 1, 0);
    busy = 0;
    while (stat_code == 3'd1 && busy < 100) begin
      busy++;
      if (busy == 3 || busy == 4) begin
        hw_wr_en[1] = 1'b1; hw_wr_addr[AW +: AW] = 5'd31; hw_wr_dat[DW +: DW] = {$urandom, $urandom};
      end else begin
        hw_wr_en[1] = 1'b0;
      end
      @(negedge clk);
    end
    hw_wr_en[1] = 1'b0;
    chk("init_stall_busy", 64'(busy), 64'd34);
    for (int i = 0; i < NE; i++) mem_m[1][i] = '0;
    compare_all();

    // opcode error then NOP
    send_cmd(4'd7, 0, 2);
    chk("op_err", 64'(stat_code), 64'd3);
    send_cmd(4'd0, 1, 9);
    chk("nop_code", 64'(stat_code), 64'd0);
    chk("nop_stat_addr", 64'(stat_addr), 64'd9);

    // error checks on the 40-entry, 3-table instance
    ed = {$urandom, $urandom} | 64'h1;
    addr = DATA; wr_dat = ed; e_wr_stb = 1'b1;
    @(negedge clk);
    e_wr_stb = 1'b0;
    chk("e_data_load", e_rd_dat, ed);
    e_cmd(4'd7, 0, 0);
    chk("e_op_err", 64'(e_stat_code), 64'd3);
    @(negedge clk);
    chk("e_op_err_hold", 64'(e_stat_code), 64'd3);
    e_cmd(4'd1, 3, 0);
    chk("e_tbl_err", 64'(e_stat_code), 64'd4);
    chk("e_tbl_err_rd_dat", e_rd_dat, ed);
    e_cmd(4'd5, 3, 40);
    chk("e_prio_op", 64'(e_stat_code), 64'd3);
    e_cmd(4'd1, 3, 40);
    chk("e_prio_tbl", 64'(e_stat_code), 64'd4);
    e_cmd(4'd2, 2, 40);
    chk("e_addr_err", 64'(e_stat_code), 64'd2);
    chk("e_addr_err_addr", 64'(e_stat_addr), 64'd40);
    chk("e_addr_err_tid", 64'(e_stat_tid), 64'd2);
    e_cmd(4'd6, 1, 3);
    e_cmd(4'd2, 3, 3);
    e_cmd(4'd2, 1, 39);
    n = 0;
    while (e_stat_code == 3'd1 && n < 20) begin n++; @(negedge clk); end
    chk("e_write_busy", 64'(n), 64'd1);
    e_hw_rd(1, 39, x);
    chk("e_t1a39", x, ed);
    e_hw_rd(1, 3, x);
    chk("e_t1a3_untouched", x, 64'd0);
    e_hw_rd(2, 39, x);
    chk("e_t2a39_untouched", x, 64'd0);
    e_cmd(4'd3, 1, 40);
    n = 0;
    while (e_stat_code == 3'd1 && n < 100) begin n++; @(negedge clk); end
    chk("e_init_busy", 64'(n), 64'd40);
    e_hw_rd(1, 39, x);
    chk("e_init_cleared", x, 64'd0);
    e_hw_wr_en[0] = 1'b1; e_hw_wr_addr[0 +: EAW] = 6'd45; e_hw_wr_dat[0 +: DW] = {$urandom, $urandom};
    @(negedge clk);
    e_hw_wr_en[0] = 1'b0;
    e_hw_rd(0, 45, x);
    chk("e_hw_rd_oob", x, 64'd0);
    e_hw_rd(0, 13, x);
    chk("e_hw_wr_oob_dropped", x, 64'd0);

    // reset during INIT at count 10
    for (int i = 0; i < 4; i++) hw_wr(i % 2, int'($urandom_range(0, NE-1)), {$urandom, $urandom} | 64'h1);
    csr_data({$urandom, $urandom} | 64'h1);
    send_cmd(4'd3, 1, 17);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_code", 64'(stat_code), 64'd0);
    chk("mid_rst_state", 64'(dbg_state), 64'd0);
    chk("mid_rst_addr", 64'(stat_addr), 64'd0);
    chk("mid_rst_rd_dat", rd_dat, 64'd0);
    chk("mid_rst_hw_rd0", hw_rd_dat[0 +: DW], 64'd0);
    chk("mid_rst_hw_rd1", hw_rd_dat[DW +: DW], 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_m = '0;
    for (int i = 0; i < NT; i++) for (int j = 0; j < NE; j++) mem_m[i][j] = '0;
    compare_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nx_rwreg_indirect_access_mt.md
# nx_rwreg_indirect_access_mt

Parametrised read/write indirect-access block owning `N_TABLES` flop-based tables of `N_ENTRIES` × `N_DATA_BITS` entries.

- **Software side:** commands arrive through the CSR command register and run READ, WRITE or INIT (table clear). Status and a data staging register are reported back.
- **Hardware side:** each table has a dedicated 1-cycle read port and write port.
- **Placement:** sits under a block's CSR decoder and generalises the read-only indirect register access to writable, multi-table storage.

## Interface
- CMND_ADDRESS, 11'h40C, CSR address whose write strobe launches a command
- DATA_ADDRESS, 11'h410, CSR address whose write strobe loads the data staging register
- N_REG_ADDR_BITS, 11, CSR address width
- N_DATA_BITS, 64, entry width
- N_ENTRIES, 32, entries per table; AW = max(1,$clog2(N_ENTRIES))
- N_TABLES, 2, table count; TW = max(1,$clog2(N_TABLES))

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- addr  in  N_REG_ADDR_BITS  CSR address
- wr_stb  in  1  CSR write strobe, single cycle
- wr_dat  in  N_DATA_BITS  CSR write data
- cmnd_op  in  4  0 NOP, 1 READ, 2 WRITE, 3 INIT
- cmnd_addr  in  AW  entry index
- cmnd_table_id  in  TW  table select
- stat_code  out  3  0 READY, 1 BUSY, 2 ADDR_ERR, 3 OP_ERR, 4 TBL_ERR
- stat_addr  out  AW  address of last accepted command
- stat_table_id  out  TW  table of last accepted command
- stat_datawords  out  5  constant ceil(N_DATA_BITS/32)
- capability_lst  out  16  constant 16'h800F
- capability_type  out  4  constant 4'd1 (RW)
- rd_dat  out  N_DATA_BITS  data staging register
- hw_rd_addr  in  N_TABLES*AW  per-table read address, table t at [t*AW +: AW]
- hw_rd_dat  out  N_TABLES*N_DATA_BITS  registered per-table read data
- hw_wr_en  in  N_TABLES  per-table write enable
- hw_wr_addr  in  N_TABLES*AW  per-table write address
- hw_wr_dat  in  N_TABLES*N_DATA_BITS  per-table write data

## Operation

**FSM states:** IDLE, EXEC, INIT.

**Command acceptance**
- A command is accepted when `wr_stb && addr==CMND_ADDRESS && state==IDLE`.
- At acceptance, `stat_addr` and `stat_table_id` capture `cmnd_addr` and `cmnd_table_id`.
- Commands arriving while not IDLE are dropped with no side effects.

**Command checks**, in priority order:
- `cmnd_op > 3` → OP_ERR
- `cmnd_table_id >= N_TABLES` → TBL_ERR
- `cmnd_addr >= N_ENTRIES` → ADDR_ERR; INIT ignores the address check

On any error, `stat_code` takes the error code next cycle, state stays IDLE, and there is no memory or `rd_dat` access. Error codes persist until the next accepted command.

**NOP:** `stat_code` = READY next cycle; nothing else changes.

**READ / WRITE:** go to EXEC with `stat_code` = BUSY.
- READ: `rd_dat <= table[tid][addr]`, return to IDLE, READY.
- WRITE: `table[tid][addr] <= rd_dat`, then IDLE, READY.
  - If `hw_wr_en[tid]` is high in that EXEC cycle, the hardware write wins. The SW write retries each following cycle until that table's `hw_wr_en` is low, with BUSY held.

**INIT:** go to INIT with BUSY and an internal counter at 0.
- Each cycle clears `table[tid][cnt]` and increments `cnt`.
- In a cycle where `hw_wr_en[tid]` is high, the hardware write is applied and the clear and increment stall.
- After entry N_ENTRIES-1 is cleared: IDLE, READY.

**Data staging register**
- `wr_stb && addr==DATA_ADDRESS` loads `rd_dat <= wr_dat` only in IDLE; it is ignored otherwise.
- If a data load and a command strobe coincide, only one `addr` value exists, so they cannot collide.

**Hardware ports**
- Reads are always serviced: `hw_rd_dat` slice t <= `table[t][hw_rd_addr t]` every cycle, read-before-write (old data on same-cycle write).
- An out-of-range `hw_rd_addr` returns 0.
- An out-of-range `hw_wr_addr` is discarded.

**Reset:** asynchronous; rst_n low mid-INIT or mid-EXEC aborts the operation. Reset values:
- all table entries, `rd_dat`, `hw_rd_dat`, `stat_addr`, `stat_table_id`: 0
- `stat_code`: READY
- state: IDLE

## Timing
- Command strobe at edge T: `stat_code` BUSY visible after T+1. READ data in `rd_dat` and READY visible after T+2.
- WRITE: memory updated at edge T+2 (+k for k conflict cycles); READY after T+2+k.
- INIT: READY after T+1+N_ENTRIES (+stall cycles).
- Error/NOP status: visible after T+1.
- Hardware read latency: 1 cycle. A SW write at edge E is visible on `hw_rd_dat` for a read address presented in cycle E (i.e. output after E+1).

## Test plan
- Reset → all outputs 0, `stat_code`=0, `capability_lst`=16'h800F, `stat_datawords`=2.
- Load data 64'hDEAD_BEEF_0123_4567, WRITE table 1 addr 5, then clear data and READ t1 a5 → `rd_dat`=64'hDEAD_BEEF_0123_4567; BUSY exactly one cycle each; `hw_rd_addr` t1=5 returns the same value; table 0 addr 5 still 0.
- WRITE t0 a3 with `hw_wr_en[0]` held 3 cycles (hw data 64'h1) → BUSY 4 cycles, final t0 a3 = SW data.
- Fill t0 via hw port, INIT t0 → BUSY 32 cycles then READY, all t0 entries 0, t1 untouched; second command strobed mid-INIT is ignored.
- `cmnd_op`=7 → OP_ERR; table 3 → TBL_ERR; addr 40 with N_ENTRIES=40 → ADDR_ERR; no memory change in any case.
- Assert rst_n mid-INIT at count 10 → immediate IDLE/READY, tables 0, `hw_rd_dat` 0.
